// File: rtl/stream_minmax_tracker_pkg.sv
// Shared types and default sizing for the stream min/max tracker.
// Optional feature macro: EQ_HITS_EN (adds the eq_hits counter and port).
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

endpackage

// File: rtl/stream_minmax_tracker_if.sv
// Sample stream in, result beat out; master = producer/consumer side, slave = tracker.
// Optional feature macro: EQ_HITS_EN (adds eq_hits to the result group).
interface stream_minmax_tracker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
`ifdef EQ_HITS_EN
  logic [CNT_W-1:0] eq_hits;
`endif

  modport master (
    output in_valid, in_data, in_last, out_ready,
`ifdef EQ_HITS_EN
    input  eq_hits,
`endif
    input  in_ready, out_valid, out_min, out_max, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
`ifdef EQ_HITS_EN
    output eq_hits,
`endif
    output in_ready, out_valid, out_min, out_max, out_count
  );

endinterface

// File: rtl/stream_minmax_tracker_mag_cmp_unit.sv
// Combinational unsigned magnitude compare of a against b; exactly one flag is high.
module mag_cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/stream_minmax_tracker.sv
// Tracks running min/max/count of a sample stream and emits one result beat after in_last.
// Optional feature macro: EQ_HITS_EN (counts samples equal to the running max).
module stream_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_minmax_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic accept;
  logic present;
  logic min_lt, min_gt, min_eq;
  logic max_lt, max_gt, max_eq;

  assign accept  = bus.in_valid & in_ready_q;
  assign present = out_valid_q & bus.out_ready;

  mag_cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (bus.in_data),
    .b  (min_q),
    .lt (min_lt),
    .gt (min_gt),
    .eq (min_eq)
  );

  mag_cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (bus.in_data),
    .b  (max_q),
    .lt (max_lt),
    .gt (max_gt),
    .eq (max_eq)
  );

  // Ties and the opposite-direction flags never change a register.
`ifdef EQ_HITS_EN
  logic cmp_flags_unused;
  assign cmp_flags_unused = &{min_gt, min_eq, max_lt, 1'b0};

  logic [CNT_W-1:0] eq_q;
  assign bus.eq_hits = eq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        eq_q <= '0;
      end else if (max_eq && (eq_q != CNT_SAT)) begin
        eq_q <= eq_q + CNT_ONE;
      end
    end
  end
`else
  logic cmp_flags_unused;
  assign cmp_flags_unused = &{min_gt, min_eq, max_lt, max_eq, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_q       <= '1;
      max_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            min_q <= bus.in_data;
            max_q <= bus.in_data;
            cnt_q <= CNT_ONE;
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (min_lt) min_q <= bus.in_data;
            if (max_gt) max_q <= bus.in_data;
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_ONE;
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Upstream is stalled for the present cycle; it reopens on the following edge.
          if (present) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
  assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Randomized and directed bench for stream_minmax_tracker; a CNT_W=2 copy shadows the main DUT.
module tb_stream_minmax_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  stream_minmax_tracker_if #(.WIDTH(4), .CNT_W(8)) bus ();
  stream_minmax_tracker_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  stream_minmax_tracker #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  stream_minmax_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model: results from the whole sequence as a list.
  function automatic int m_min(input int q[$]);
    int r = q[0];
    foreach (q[i]) if (q[i] < r) r = q[i];
    return r;
  endfunction

  function automatic int m_max(input int q[$]);
    int r = q[0];
    foreach (q[i]) if (q[i] > r) r = q[i];
    return r;
  endfunction

  function automatic int m_count(input int q[$], input int sat);
    return (q.size() > sat) ? sat : q.size();
  endfunction

  function automatic int m_eq(input int q[$], input int sat);
    int run = q[0];
    int hits = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] == run) hits++;
      if (q[i] > run) run = q[i];
    end
    return (hits > sat) ? sat : hits;
  endfunction

  task automatic push(input int d, input bit last, input int gap);
    bit ok = 0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.in_last = 1'($urandom_range(0, 1));
      bus.in_data = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(d);
    bus.in_last  = last;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!ok) $display("FAIL push_timeout in_ready=%0b required 1", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt += 5;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); else pass_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    if (bus.out_min !== 4'hF) $display("FAIL rst_out_min got %0h want f", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'h0) $display("FAIL rst_out_max got %0h want 0", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd0) $display("FAIL rst_out_count got %0d want 0", bus.out_count); else pass_cnt++;
`ifdef EQ_HITS_EN
    total_cnt++;
    if (bus.eq_hits !== 8'd0) $display("FAIL rst_eq_hits got %0d want 0", bus.eq_hits); else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    push(5, 0, 0);
    push(2, 0, 0);
    push(9, 0, 0);
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    push(9, 1, 0);
    total_cnt += 6;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_latency out_valid got %0b want 1", bus.out_valid); else pass_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL basic_in_ready got %0b want 0", bus.in_ready); else pass_cnt++;
    if (bus.out_min !== 4'd2) $display("FAIL basic_min got %0d want 2", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'd9) $display("FAIL basic_max got %0d want 9", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd4) $display("FAIL basic_count got %0d want 4", bus.out_count); else pass_cnt++;
    if (bus2.out_count !== 2'd3) $display("FAIL basic_count_sat got %0d want 3", bus2.out_count); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt += 2;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_drop_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL basic_reopen got %0b want 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b0;
    push(7, 1, 0);
    total_cnt += 4;
    if (bus.out_min !== 4'd7) $display("FAIL single_min got %0d want 7", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'd7) $display("FAIL single_max got %0d want 7", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd1) $display("FAIL single_count got %0d want 1", bus.out_count); else pass_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL single_present_ready got %0b want 0", bus.in_ready); else pass_cnt++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt += 2;
    if (bus.in_ready !== 1'b1) $display("FAIL single_reopen got %0b want 1", bus.in_ready); else pass_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL single_drop_valid got %0b want 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    push(1, 0, 0);
    push(14, 0, 0);
    push(6, 1, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt += 5;
      if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready c%0d got %0b want 0", c, bus.in_ready); else pass_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL hold_valid c%0d got %0b want 1", c, bus.out_valid); else pass_cnt++;
      if (bus.out_min !== 4'd1) $display("FAIL hold_min c%0d got %0d want 1", c, bus.out_min); else pass_cnt++;
      if (bus.out_max !== 4'd14) $display("FAIL hold_max c%0d got %0d want 14", c, bus.out_max); else pass_cnt++;
      if (bus.out_count !== 8'd3) $display("FAIL hold_count c%0d got %0d want 3", c, bus.out_count); else pass_cnt++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL hold_release got %0b want 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int q[$] = '{9, 0, 15, 3, 12, 5};
    bus.out_ready = 1'b0;
    foreach (q[i]) push(q[i], i == q.size() - 1, 0);
    total_cnt += 4;
    if (bus2.out_count !== 2'd3) $display("FAIL sat_count got %0d want 3", bus2.out_count); else pass_cnt++;
    if (bus2.out_min !== 4'd0) $display("FAIL sat_min got %0d want 0", bus2.out_min); else pass_cnt++;
    if (bus2.out_max !== 4'd15) $display("FAIL sat_max got %0d want 15", bus2.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd6) $display("FAIL sat_wide_count got %0d want 6", bus.out_count); else pass_cnt++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    push(10, 0, 0);
    push(11, 0, 0);
    push(12, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt += 5;
    if (bus.in_ready !== 1'b1) $display("FAIL mrst_in_ready got %0b want 1", bus.in_ready); else pass_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL mrst_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    if (bus.out_min !== 4'hF) $display("FAIL mrst_min got %0h want f", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'h0) $display("FAIL mrst_max got %0h want 0", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd0) $display("FAIL mrst_count got %0d want 0", bus.out_count); else pass_cnt++;
`ifdef EQ_HITS_EN
    total_cnt++;
    if (bus.eq_hits !== 8'd0) $display("FAIL mrst_eq_hits got %0d want 0", bus.eq_hits); else pass_cnt++;
`endif
    push(3, 0, 0);
    push(4, 1, 0);
    total_cnt += 3;
    if (bus.out_min !== 4'd3) $display("FAIL mrst_new_min got %0d want 3", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'd4) $display("FAIL mrst_new_max got %0d want 4", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd2) $display("FAIL mrst_new_count got %0d want 2", bus.out_count); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_eq_hits();
    int q[$] = '{4, 4, 8, 8, 8, 1};
    bus.out_ready = 1'b0;
    foreach (q[i]) push(q[i], i == q.size() - 1, 0);
    total_cnt += 3;
    if (bus.out_min !== 4'd1) $display("FAIL eq_min got %0d want 1", bus.out_min); else pass_cnt++;
    if (bus.out_max !== 4'd8) $display("FAIL eq_max got %0d want 8", bus.out_max); else pass_cnt++;
    if (bus.out_count !== 8'd6) $display("FAIL eq_count got %0d want 6", bus.out_count); else pass_cnt++;
`ifdef EQ_HITS_EN
    total_cnt += 2;
    if (bus.eq_hits !== 8'd3) $display("FAIL eq_hits got %0d want 3", bus.eq_hits); else pass_cnt++;
    if (bus2.eq_hits !== 2'd3) $display("FAIL eq_hits_sat got %0d want 3", bus2.eq_hits); else pass_cnt++;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int s = 0; s < 40; s++) begin
      int q[$];
      int len;
      int stall;
      len = (s % 10 == 9) ? $urandom_range(250, 270) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 15));
      bus.out_ready = 1'($urandom_range(0, 1));
      foreach (q[i]) push(q[i], i == len - 1, (len > 20) ? 0 : $urandom_range(0, 2));
      total_cnt += 6;
      if (bus.out_valid !== 1'b1) $display("FAIL rnd%0d_valid got %0b want 1", s, bus.out_valid); else pass_cnt++;
      if (int'(bus.out_min) !== m_min(q)) $display("FAIL rnd%0d_min got %0d want %0d", s, bus.out_min, m_min(q)); else pass_cnt++;
      if (int'(bus.out_max) !== m_max(q)) $display("FAIL rnd%0d_max got %0d want %0d", s, bus.out_max, m_max(q)); else pass_cnt++;
      if (int'(bus.out_count) !== m_count(q, 255)) $display("FAIL rnd%0d_count got %0d want %0d", s, bus.out_count, m_count(q, 255)); else pass_cnt++;
      if (int'(bus2.out_count) !== m_count(q, 3)) $display("FAIL rnd%0d_count_sat got %0d want %0d", s, bus2.out_count, m_count(q, 3)); else pass_cnt++;
      if (int'(bus2.out_max) !== m_max(q)) $display("FAIL rnd%0d_max_n got %0d want %0d", s, bus2.out_max, m_max(q)); else pass_cnt++;
`ifdef EQ_HITS_EN
      total_cnt += 2;
      if (int'(bus.eq_hits) !== m_eq(q, 255)) $display("FAIL rnd%0d_eq got %0d want %0d", s, bus.eq_hits, m_eq(q, 255)); else pass_cnt++;
      if (int'(bus2.eq_hits) !== m_eq(q, 3)) $display("FAIL rnd%0d_eq_sat got %0d want %0d", s, bus2.eq_hits, m_eq(q, 3)); else pass_cnt++;
`endif
      if (!bus.out_ready) begin
        stall = $urandom_range(0, 3);
        for (int c = 0; c < stall; c++) begin @(posedge clk); #1; end
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL rnd%0d_stall_valid got %0b want 1", s, bus.out_valid); else pass_cnt++;
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL rnd%0d_drop got %0b want 0", s, bus.out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_hold();
    test_saturation();
    test_mid_reset();
    test_eq_hits();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
